// File: rtl/program_loader.sv
// Byte-stream program loader: writes 10-bit words into instruction RAM while the CPU is halted.
// Define PROGRAM_LOADER_CHECKSUM_EN to require an 8-bit payload checksum byte after the last word.
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 10
) (
    input  logic              CLK,
    input  logic              ARST_L,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [WORD_W-1:0] prog_data,
    output logic              prog_wr,
    output logic              HALT,
    output logic              cpu_restart,
    output logic              load_busy,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_LO, S_HI, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        lo_q, lo_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              halt_q, halt_d;
    logic              err_q, err_d;
    logic              rdy_q, rdy_d;
    logic              wr_q, wr_d;
    logic              rst_q, rst_d;
    logic              busy_q, busy_d;
    logic              hs;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // Ready is registered from the next state, so it depends on state only.
    assign hs = byte_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        data_d  = data_q;
        halt_d  = halt_q;
        err_d   = err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_d = S_COUNT;
                    halt_d  = 1'b1;
                    addr_d  = '0;
                    err_d   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_COUNT: begin
                if (hs) begin
                    cnt_d = ADDR_W'(byte_data);
                    if (ADDR_W'(byte_data) == '0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (hs) begin
                    lo_d    = byte_data;
                    state_d = S_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + byte_data;
`endif
                end
            end
            S_HI: begin
                if (hs) begin
                    data_d  = WORD_W'({byte_data[1:0], lo_q});
                    state_d = S_WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + byte_data;
`endif
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == ADDR_W'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
                    halt_d  = 1'b0;
`endif
                end else begin
                    state_d = S_LO;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (hs) begin
                    if (byte_data == sum_q) begin
                        state_d = S_DONE;
                        halt_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        rdy_d  = (state_d == S_COUNT) || (state_d == S_LO) ||
                 (state_d == S_HI) || (state_d == S_CSUM);
        wr_d   = (state_d == S_WRITE);
        rst_d  = (state_d == S_DONE) && (state_q != S_DONE);
        busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                   (state_d == S_ERR));
    end

    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            rst_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            wr_q    <= wr_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign byte_ready  = rdy_q;
    assign prog_addr   = addr_q;
    assign prog_data   = data_q;
    assign prog_wr     = wr_q;
    assign HALT        = halt_q;
    assign cpu_restart = rst_q;
    assign load_busy   = busy_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: basic load, stalls, zero count,
// checksum, busy restart and mid-load reset.
module tb_program_loader;

    logic       CLK = 1'b0;
    logic       ARST_L = 1'b0;
    logic       load_start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready;
    logic [7:0] prog_addr;
    logic [9:0] prog_data;
    logic       prog_wr;
    logic       HALT;
    logic       cpu_restart;
    logic       load_busy;
    logic       load_err;

    program_loader #(.ADDR_W(8), .WORD_W(10)) dut (
        .CLK(CLK), .ARST_L(ARST_L), .load_start(load_start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_wr(prog_wr), .HALT(HALT),
        .cpu_restart(cpu_restart), .load_busy(load_busy),
        .load_err(load_err)
    );

    always #5 CLK = ~CLK;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    int         cyc = 0;
    int         nw = 0;
    int         nrs = 0;
    int         bad_rdy = 0;
    int         bad_halt = 0;
    logic [7:0] wa [64];
    logic [9:0] wd [64];
    int         wc [64];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (prog_wr) begin
            if (nw < 64) begin
                wa[nw] <= prog_addr;
                wd[nw] <= prog_data;
                wc[nw] <= cyc;
            end
            nw <= nw + 1;
            if (byte_ready) bad_rdy <= bad_rdy + 1;
        end
        if (cpu_restart) nrs <= nrs + 1;
        if (load_busy && !HALT) bad_halt <= bad_halt + 1;
    end

    int         errors = 0;
    int         checks = 0;
    int         s_cyc = 0;
    int         done_cyc = 0;
    int         base = 0;
    int         rbase = 0;
    logic [7:0] img [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        @(negedge CLK);
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic stream(input bit stall, input int ls_at,
                          input int rst_at);
        int i = 0;
        int c = 0;
        bit tog = 1'b1;
        bit hs;
        while (i < img.size() && c < 200) begin
            if (rst_at == i && byte_ready) begin
                ARST_L = 1'b0;
                byte_valid = 1'b0;
                break;
            end
            load_start = (ls_at == i) && byte_ready;
            byte_valid = stall ? tog : 1'b1;
            tog = ~tog;
            byte_data = img[i];
            hs = byte_valid && byte_ready;
            @(negedge CLK);
            c++;
            if (hs) i++;
        end
        byte_valid = 1'b0;
        load_start = 1'b0;
        chk("stream_timeout", 32'(c >= 200), 0);
    endtask

    task automatic wait_done();
        int c = 0;
        while (HALT && c < 60) begin
            @(negedge CLK);
            c++;
        end
        done_cyc = cyc;
        chk("done_timeout", 32'(c >= 60), 0);
    endtask

    task automatic basic_img();
        img = '{8'h03, 8'h12, 8'h01, 8'h34, 8'h02, 8'hFF, 8'h03};
        if (CK != 0) img.push_back(8'h4B);
    endtask

    task automatic check_basic_writes(input string tag);
        chk({tag, "_nw"}, nw - base, 3);
        chk({tag, "_a0"}, wa[base], 0);
        chk({tag, "_d0"}, wd[base], 10'h112);
        chk({tag, "_a1"}, wa[base+1], 1);
        chk({tag, "_d1"}, wd[base+1], 10'h234);
        chk({tag, "_a2"}, wa[base+2], 2);
        chk({tag, "_d2"}, wd[base+2], 10'h3FF);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_ready", byte_ready, 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_data", prog_data, 0);
        chk("rst_wr", prog_wr, 0);
        chk("rst_halt", HALT, 0);
        chk("rst_restart", cpu_restart, 0);
        chk("rst_busy", load_busy, 0);
        chk("rst_err", load_err, 0);
        ARST_L = 1'b1;
        repeat (2) @(negedge CLK);

        // Basic load at full rate
        basic_img();
        base = nw;
        rbase = nrs;
        start();
        chk("b_halt_on", HALT, 1);
        chk("b_busy_on", load_busy, 1);
        stream(1'b0, -1, -1);
        wait_done();
        chk("b_done_cyc", done_cyc - s_cyc, 10 + CK);
        chk("b_restart", cpu_restart, 1);
        chk("b_busy_off", load_busy, 0);
        @(negedge CLK);
        chk("b_restart_end", cpu_restart, 0);
        @(negedge CLK);
        check_basic_writes("b");
        chk("b_wc0", wc[base] - s_cyc, 3);
        chk("b_wc1", wc[base+1] - wc[base], 3);
        chk("b_wc2", wc[base+2] - wc[base+1], 3);
        chk("b_nrs", nrs - rbase, 1);
        chk("b_err", load_err, 0);

        // Source stalls every other cycle
        basic_img();
        base = nw;
        rbase = nrs;
        start();
        stream(1'b1, -1, -1);
        wait_done();
        repeat (3) @(negedge CLK);
        check_basic_writes("s");
        chk("s_nrs", nrs - rbase, 1);
        chk("s_halt", HALT, 0);

        // Zero count
        img = '{8'h00};
        base = nw;
        rbase = nrs;
        start();
        stream(1'b0, -1, -1);
        repeat (3) @(negedge CLK);
        chk("z_err", load_err, 1);
        chk("z_halt", HALT, 1);
        chk("z_busy", load_busy, 0);
        chk("z_ready", byte_ready, 0);
        chk("z_nw", nw - base, 0);
        chk("z_nrs", nrs - rbase, 0);
        start();
        chk("z_err_clr", load_err, 0);
        chk("z_busy_again", load_busy, 1);
        chk("z_halt_again", HALT, 1);

        // Single word, optional checksum 0x11
        img = '{8'h01, 8'h10, 8'h01};
        if (CK != 0) img.push_back(8'h11);
        stream(1'b0, -1, -1);
        wait_done();
        chk("c_done_cyc", done_cyc - s_cyc, 4 + CK);
        repeat (2) @(negedge CLK);
        chk("c_nw", nw - base, 1);
        chk("c_a0", wa[base], 0);
        chk("c_d0", wd[base], 10'h110);
        chk("c_err", load_err, 0);
        chk("c_nrs", nrs - rbase, 1);

        if (CK != 0) begin
            img = '{8'h01, 8'h10, 8'h01, 8'h12};
            base = nw;
            rbase = nrs;
            start();
            stream(1'b0, -1, -1);
            repeat (3) @(negedge CLK);
            chk("k_err", load_err, 1);
            chk("k_halt", HALT, 1);
            chk("k_busy", load_busy, 0);
            chk("k_nw", nw - base, 1);
            chk("k_nrs", nrs - rbase, 0);
        end

        // load_start during LO of word 2 is ignored
        basic_img();
        base = nw;
        rbase = nrs;
        start();
        stream(1'b0, 3, -1);
        wait_done();
        chk("r_done_cyc", done_cyc - s_cyc, 10 + CK);
        repeat (2) @(negedge CLK);
        check_basic_writes("r");
        chk("r_nrs", nrs - rbase, 1);

        // Reset during HI of word 2 of 4
        img = '{8'h04, 8'h01, 8'h00, 8'h02, 8'h00,
                8'h03, 8'h00, 8'h04, 8'h00};
        if (CK != 0) img.push_back(8'h0A);
        base = nw;
        rbase = nrs;
        start();
        stream(1'b0, -1, 4);
        #1;
        chk("m_ready", byte_ready, 0);
        chk("m_addr", prog_addr, 0);
        chk("m_data", prog_data, 0);
        chk("m_wr", prog_wr, 0);
        chk("m_halt", HALT, 0);
        chk("m_restart", cpu_restart, 0);
        chk("m_busy", load_busy, 0);
        chk("m_err", load_err, 0);
        @(negedge CLK);
        ARST_L = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'h00;
        repeat (10) @(negedge CLK);
        byte_valid = 1'b0;
        @(negedge CLK);
        chk("m_nw", nw - base, 1);
        chk("m_nrs", nrs - rbase, 0);
        chk("m_halt_after", HALT, 0);

        chk("bad_ready_in_write", bad_rdy, 0);
        chk("halt_low_while_busy", bad_halt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
